multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Multicycle control FSM for the 64-bit RISC-V datapath. It sequences every instruction through fetch, decode, execute, memory, write-back and PC update. It drives all datapath strobes and mux selects (`we`, `we_ram`, `load_PC`, `load_IR`, `decisor0..6`, `somador_subtrator`) from the IR contents and the branch flags. It sits beside the datapath and replaces bench-driven control sequencing.

## Interface
- No parameters.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `saida_IR` in 32: instruction register contents from the datapath.
- `BEQ BNE BGE BLT BGEU BLTU` in 1 each: comparator flags from the datapath.
- `we` out 1: register-file write strobe.
- `we_ram` out 1: data-RAM write strobe.
- `load_PC` out 1: PC load strobe.
- `load_IR` out 1: IR load strobe.
- `decisor0` out 1: ALU B operand; 0 = Rb, 1 = immediate.
- `decisor1` out 1: immediate format; 1 = I-type, 0 = S-type.
- `decisor2` out 1: RF data source; 1 = RAM, 0 = ALU.
- `decisor3` out 1: PC source; 0 = `PCres` vector, 1 = PC adder.
- `decisor4` out 1: PC adder operand; 0 = constant 4, 1 = `imm_PC`.
- `decisor5` out 1: RF write path; 1 = ALU/RAM, 0 = PC adder.
- `decisor6` out 1: PC adder base; 0 = PC, 1 = rs1.
- `somador_subtrator` out 1: ALU mode; 1 = subtract.
- `halted` out 1: FSM is in HALT.
- `illegal` out 1: HALT was caused by an unsupported instruction.
- `instr_count` out 32: count of retired instructions.
- `state` out 3: current FSM state, for debug.

## Operation
- All outputs are Moore: decoded from registered state plus registered decode fields captured in DECODE.
- States and encoding: RST=0, INIT=1, FETCH=2, DECODE=3, EXEC=4, MEM=5, WB=6, NEXT=7. HALT is encoded as RST with `halted`=1.
- INIT: `load_PC`=1, `decisor3`=0. Loads the reset vector, then goes to FETCH.
- FETCH: `load_IR`=1. All selects at their reset values.
- DECODE: registers class, rd, rs1, funct3, funct7[5]. Unsupported instruction → HALT with `illegal`=1.
- Supported instructions:
  - 0110011, funct3=000 (add/sub)
  - 0010011, funct3=000 (addi)
  - 0000011, funct3=011 (ld)
  - 0100011, funct3=011 (sd)
  - 1100011, funct3 ∈ {000,001,100,101,110,111}
  - 0010111 (auipc), 1101111 (jal), 1100111 (jalr)
  - Everything else is illegal.
- jalr with rd==rs1 and rd≠0 is illegal. Linking would corrupt the base before the target is computed.
- Selects are stable from DECODE through NEXT. Strobes last exactly one cycle.
- State paths per class:
  - R/addi: EXEC → WB(`we`) → NEXT. `decisor0`=1 for addi, 0 for R. `somador_subtrator`=funct7[5] for R, 0 for addi.
  - ld: EXEC → MEM → WB(`we`, `decisor2`=1) → NEXT. `decisor0`=1, `decisor1`=1.
  - sd: EXEC → MEM(`we_ram`) → NEXT. `decisor0`=1, `decisor1`=0.
  - branch: EXEC → NEXT. `somador_subtrator`=1. In EXEC, the flag selected by funct3 (BEQ, BNE, BLT, BGE, BLTU, BGEU) is registered into `taken`. NEXT drives `decisor4`=`taken`.
  - auipc: EXEC → WB(`we`, `decisor5`=0, `decisor4`=1) → NEXT with `decisor4`=0.
  - jal: EXEC → WB(`we`, `decisor5`=0, `decisor4`=0) → NEXT with `decisor4`=1.
  - jalr: same as jal, plus `decisor6`=1 in NEXT.
- NEXT: `load_PC`=1, `decisor3`=1, `instr_count` increments (wraps at 2^32−1 → 0), then FETCH.
- HALT: all strobes 0. Held until `reset`.

## Timing
- Reset values, effective the cycle after `reset` is sampled high:
  - All strobes 0.
  - `decisor0-4`, `decisor6` = 0; `decisor5` = 1.
  - `somador_subtrator`=0, `halted`=0, `illegal`=0, `instr_count`=0, `state`=RST.
- First cycle after reset deasserts: RST → INIT. Then FETCH.
- Latency in cycles, counted from FETCH inclusive:
  - branch: 4
  - R, addi, sd, auipc, jal, jalr: 5
  - ld: 6
  - illegal: HALT entered 2 cycles after FETCH.
- Reset in any state, including mid-WB or MEM, wins. No `we`, `we_ram` or `load_PC` is asserted in the following cycle, and the aborted instruction is not counted.
- `taken` is sampled only in EXEC. Flag changes during NEXT are ignored.

## Test plan
- Reset, then IR=0x00910093 (addi x1,x2,9): FETCH at c0, `we`=1 only at c3 with `decisor0`=1; `load_PC`=1 at c4; `instr_count`=1.
- IR=0x00103203 (ld x4,1(x0)): MEM at c3, `we`=1 with `decisor2`=1 at c4, `load_PC` at c5; `we_ram` never asserted.
- IR=0x00411463 (bne x2,x4,+8), BNE=1 at EXEC → `decisor4`=1 in NEXT; rerun with BNE=0 → `decisor4`=0; neither run asserts `we`.
- IR=0x008000EF (jal x1,+8): WB has `decisor5`=0, `decisor4`=0; NEXT has `decisor4`=1, `decisor6`=0.
- IR=0x00000000, then IR=0x00010167 (jalr x2,0(x2)): both give `halted`=`illegal`=1 at c2, no strobes afterwards, `instr_count` unchanged.
- Assert `reset` during WB of ld: next cycle `we`=0, `state`=RST, `instr_count`=0, `decisor5`=1.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multicycle control unit for the 64-bit RISC-V datapath.
// Steps every instruction through fetch, decode, execute, memory, write-back
// and PC update. All datapath strobes and selects come from registers, so
// every output is a clean Moore function of the FSM.
module multicycle_control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] saida_IR,
    input  logic        BEQ,
    input  logic        BNE,
    input  logic        BGE,
    input  logic        BLT,
    input  logic        BGEU,
    input  logic        BLTU,
    output logic        we,
    output logic        we_ram,
    output logic        load_PC,
    output logic        load_IR,
    output logic        decisor0,
    output logic        decisor1,
    output logic        decisor2,
    output logic        decisor3,
    output logic        decisor4,
    output logic        decisor5,
    output logic        decisor6,
    output logic        somador_subtrator,
    output logic        halted,
    output logic        illegal,
    output logic [31:0] instr_count,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_INIT   = 3'd1,
        S_FETCH  = 3'd2,
        S_DECODE = 3'd3,
        S_EXEC   = 3'd4,
        S_MEM    = 3'd5,
        S_WB     = 3'd6,
        S_NEXT   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU    = 3'd0,
        CLS_ALUI   = 3'd1,
        CLS_LOAD   = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_BRANCH = 3'd4,
        CLS_AUIPC  = 3'd5,
        CLS_JAL    = 3'd6,
        CLS_JALR   = 3'd7
    } class_t;

    state_t      state_q;
    class_t      class_q;
    class_t      class_d;
    logic        legal_d;
    logic [2:0]  funct3_q;
    logic        takenSel;

    logic        we_q;
    logic        weRam_q;
    logic        loadPc_q;
    logic        loadIr_q;
    logic        d0_q;
    logic        d1_q;
    logic        d2_q;
    logic        d3_q;
    logic        d4_q;
    logic        d5_q;
    logic        d6_q;
    logic        sub_q;
    logic        halted_q;
    logic        illegal_q;
    logic [31:0] count_q;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic        unusedIr;

    assign opcode   = saida_IR[6:0];
    assign rd       = saida_IR[11:7];
    assign funct3   = saida_IR[14:12];
    assign rs1      = saida_IR[19:15];
    // Immediate and rs2 bits belong to the datapath, not to sequencing.
    assign unusedIr = ^{saida_IR[31], saida_IR[29:20]};

    // Classify the instruction register and flag anything we cannot sequence.
    always_comb begin
        legal_d = 1'b1;
        class_d = CLS_ALU;
        case (opcode)
            7'b0110011: begin class_d = CLS_ALU;    legal_d = (funct3 == 3'b000); end
            7'b0010011: begin class_d = CLS_ALUI;   legal_d = (funct3 == 3'b000); end
            7'b0000011: begin class_d = CLS_LOAD;   legal_d = (funct3 == 3'b011); end
            7'b0100011: begin class_d = CLS_STORE;  legal_d = (funct3 == 3'b011); end
            7'b1100011: begin
                class_d = CLS_BRANCH;
                legal_d = (funct3 != 3'b010) && (funct3 != 3'b011);
            end
            7'b0010111: class_d = CLS_AUIPC;
            7'b1101111: class_d = CLS_JAL;
            7'b1100111: begin
                // Linking into the base register would destroy the target base.
                class_d = CLS_JALR;
                legal_d = !((rd == rs1) && (rd != 5'd0));
            end
            default:    legal_d = 1'b0;
        endcase
    end

    // Pick the comparator flag that the latched branch funct3 refers to.
    always_comb begin
        takenSel = 1'b0;
        case (funct3_q)
            3'b000:  takenSel = BEQ;
            3'b001:  takenSel = BNE;
            3'b100:  takenSel = BLT;
            3'b101:  takenSel = BGE;
            3'b110:  takenSel = BLTU;
            3'b111:  takenSel = BGEU;
            default: takenSel = 1'b0;
        endcase
    end

    // Sequencer: each transition also loads the outputs of the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_RST;
            class_q   <= CLS_ALU;
            funct3_q  <= 3'b000;
            we_q      <= 1'b0;
            weRam_q   <= 1'b0;
            loadPc_q  <= 1'b0;
            loadIr_q  <= 1'b0;
            d0_q      <= 1'b0;
            d1_q      <= 1'b0;
            d2_q      <= 1'b0;
            d3_q      <= 1'b0;
            d4_q      <= 1'b0;
            d5_q      <= 1'b1;
            d6_q      <= 1'b0;
            sub_q     <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            count_q   <= 32'd0;
        end else begin
            we_q     <= 1'b0;
            weRam_q  <= 1'b0;
            loadPc_q <= 1'b0;
            loadIr_q <= 1'b0;
            case (state_q)
                S_RST: begin
                    if (!halted_q) begin
                        state_q  <= S_INIT;
                        loadPc_q <= 1'b1;
                    end
                end
                S_INIT: begin
                    state_q  <= S_FETCH;
                    loadIr_q <= 1'b1;
                end
                S_FETCH: begin
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    if (legal_d) begin
                        state_q  <= S_EXEC;
                        class_q  <= class_d;
                        funct3_q <= funct3;
                        d0_q     <= (class_d == CLS_ALUI) || (class_d == CLS_LOAD) ||
                                    (class_d == CLS_STORE);
                        d1_q     <= (class_d == CLS_ALUI) || (class_d == CLS_LOAD);
                        d2_q     <= (class_d == CLS_LOAD);
                        d3_q     <= 1'b0;
                        d4_q     <= (class_d == CLS_AUIPC);
                        d5_q     <= !(class_d inside {CLS_AUIPC, CLS_JAL, CLS_JALR});
                        d6_q     <= 1'b0;
                        sub_q    <= ((class_d == CLS_ALU) && saida_IR[30]) ||
                                    (class_d == CLS_BRANCH);
                    end else begin
                        state_q   <= S_RST;
                        halted_q  <= 1'b1;
                        illegal_q <= 1'b1;
                    end
                end
                S_EXEC: begin
                    case (class_q)
                        CLS_LOAD: begin
                            state_q <= S_MEM;
                        end
                        CLS_STORE: begin
                            state_q <= S_MEM;
                            weRam_q <= 1'b1;
                        end
                        CLS_BRANCH: begin
                            state_q  <= S_NEXT;
                            loadPc_q <= 1'b1;
                            d3_q     <= 1'b1;
                            d4_q     <= takenSel;
                        end
                        default: begin
                            state_q <= S_WB;
                            we_q    <= 1'b1;
                        end
                    endcase
                end
                S_MEM: begin
                    if (class_q == CLS_LOAD) begin
                        state_q <= S_WB;
                        we_q    <= 1'b1;
                    end else begin
                        state_q  <= S_NEXT;
                        loadPc_q <= 1'b1;
                        d3_q     <= 1'b1;
                    end
                end
                S_WB: begin
                    state_q  <= S_NEXT;
                    loadPc_q <= 1'b1;
                    d3_q     <= 1'b1;
                    d4_q     <= (class_q == CLS_JAL) || (class_q == CLS_JALR);
                    d6_q     <= (class_q == CLS_JALR);
                end
                S_NEXT: begin
                    state_q  <= S_FETCH;
                    loadIr_q <= 1'b1;
                    count_q  <= count_q + 32'd1;
                    d0_q     <= 1'b0;
                    d1_q     <= 1'b0;
                    d2_q     <= 1'b0;
                    d3_q     <= 1'b0;
                    d4_q     <= 1'b0;
                    d5_q     <= 1'b1;
                    d6_q     <= 1'b0;
                    sub_q    <= 1'b0;
                end
                default: begin
                    state_q <= S_RST;
                end
            endcase
        end
    end

    assign we                = we_q;
    assign we_ram            = weRam_q;
    assign load_PC           = loadPc_q;
    assign load_IR           = loadIr_q;
    assign decisor0          = d0_q;
    assign decisor1          = d1_q;
    assign decisor2          = d2_q;
    assign decisor3          = d3_q;
    assign decisor4          = d4_q;
    assign decisor5          = d5_q;
    assign decisor6          = d6_q;
    assign somador_subtrator = sub_q;
    assign halted            = halted_q;
    assign illegal           = illegal_q;
    assign instr_count       = count_q;
    assign state             = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: instructions are issued at FETCH, their
// expected per-instruction behaviour is queued, and a monitor rebuilds what
// the DUT actually did for each instruction and compares it with the queue.
module tb_multicycle_control_unit;

    localparam int NF       = 21;
    localparam int F_HALT   = 0;
    localparam int F_ILL    = 1;
    localparam int F_LAST   = 2;
    localparam int F_WECYC  = 3;
    localparam int F_RAMCYC = 4;
    localparam int F_WECNT  = 5;
    localparam int F_RAMCNT = 6;
    localparam int F_PCCNT  = 7;
    localparam int F_IRCNT  = 8;
    localparam int F_WBD0   = 9;
    localparam int F_WBD1   = 10;
    localparam int F_WBD2   = 11;
    localparam int F_WBD4   = 12;
    localparam int F_WBD5   = 13;
    localparam int F_WBSUB  = 14;
    localparam int F_RAMD0  = 15;
    localparam int F_RAMD1  = 16;
    localparam int F_ND4    = 17;
    localparam int F_ND6    = 18;
    localparam int F_NSUB   = 19;
    localparam int F_CNT    = 20;

    localparam logic [31:0] DC   = 32'hFFFF_FFFF;
    localparam logic [31:0] NONE = 32'd99;

    typedef logic [NF-1:0][31:0] rec_t;

    string fieldName [NF] = '{"halted", "illegal", "last cycle", "we cycle", "we_ram cycle",
                              "we count", "we_ram count", "load_PC count", "load_IR count",
                              "wb decisor0", "wb decisor1", "wb decisor2", "wb decisor4",
                              "wb decisor5", "wb sub", "mem decisor0", "mem decisor1",
                              "next decisor4", "next decisor6", "next sub", "instr_count"};

    logic        clk;
    logic        reset;
    logic [31:0] saida_IR;
    logic        BEQ, BNE, BGE, BLT, BGEU, BLTU;
    logic        we, we_ram, load_PC, load_IR;
    logic        decisor0, decisor1, decisor2, decisor3, decisor4, decisor5, decisor6;
    logic        somador_subtrator, halted, illegal;
    logic [31:0] instr_count;
    logic [2:0]  state;

    int   checks = 0;
    int   errors = 0;
    int   modelCount = 0;
    rec_t sbQ [$];

    multicycle_control_unit dut (
        .clk(clk), .reset(reset), .saida_IR(saida_IR),
        .BEQ(BEQ), .BNE(BNE), .BGE(BGE), .BLT(BLT), .BGEU(BGEU), .BLTU(BLTU),
        .we(we), .we_ram(we_ram), .load_PC(load_PC), .load_IR(load_IR),
        .decisor0(decisor0), .decisor1(decisor1), .decisor2(decisor2), .decisor3(decisor3),
        .decisor4(decisor4), .decisor5(decisor5), .decisor6(decisor6),
        .somador_subtrator(somador_subtrator), .halted(halted), .illegal(illegal),
        .instr_count(instr_count), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] b2w(input logic b);
        return {31'd0, b};
    endfunction

    // Reference: what one instruction must look like, cycles counted from FETCH = 0.
    // flg bits: 0 BEQ, 1 BNE, 2 BLT, 3 BGE, 4 BLTU, 5 BGEU.
    function automatic rec_t model(input logic [31:0] ir, input logic [5:0] flg, input int cnt);
        rec_t       r;
        logic [6:0] op;
        logic [2:0] f3;
        logic [4:0] rd, rs1;
        bit isR, isI, isLd, isSd, isBr, isAu, isJal, isJalr, taken;
        for (int i = 0; i < NF; i++) r[i] = DC;
        op  = ir[6:0];
        f3  = ir[14:12];
        rd  = ir[11:7];
        rs1 = ir[19:15];
        isR    = (op == 7'h33) && (f3 == 3'd0);
        isI    = (op == 7'h13) && (f3 == 3'd0);
        isLd   = (op == 7'h03) && (f3 == 3'd3);
        isSd   = (op == 7'h23) && (f3 == 3'd3);
        isBr   = (op == 7'h63) && (f3 != 3'd2) && (f3 != 3'd3);
        isAu   = (op == 7'h17);
        isJal  = (op == 7'h6F);
        isJalr = (op == 7'h67) && !((rd == rs1) && (rd != 5'd0));
        r[F_IRCNT] = 1;
        if (!(isR || isI || isLd || isSd || isBr || isAu || isJal || isJalr)) begin
            r[F_HALT]   = 1;
            r[F_ILL]    = 1;
            r[F_LAST]   = 2;
            r[F_WECNT]  = 0;
            r[F_RAMCNT] = 0;
            r[F_PCCNT]  = 0;
            r[F_CNT]    = cnt;
            return r;
        end
        case (f3)
            3'd0:    taken = flg[0];
            3'd1:    taken = flg[1];
            3'd4:    taken = flg[2];
            3'd5:    taken = flg[3];
            3'd6:    taken = flg[4];
            default: taken = flg[5];
        endcase
        r[F_HALT]   = 0;
        r[F_ILL]    = 0;
        r[F_PCCNT]  = 1;
        r[F_CNT]    = cnt + 1;
        r[F_LAST]   = isBr ? 3 : (isLd ? 5 : 4);
        r[F_WECNT]  = (isSd || isBr) ? 0 : 1;
        r[F_WECYC]  = isLd ? 4 : ((isSd || isBr) ? NONE : 3);
        r[F_RAMCNT] = isSd ? 1 : 0;
        r[F_RAMCYC] = isSd ? 3 : NONE;
        r[F_ND4]    = isBr ? (taken ? 1 : 0) : ((isJal || isJalr) ? 1 : 0);
        r[F_ND6]    = isJalr ? 1 : 0;
        if (isR)  begin r[F_WBD0] = 0; r[F_WBSUB] = ir[30] ? 1 : 0; r[F_WBD2] = 0; r[F_WBD5] = 1; end
        if (isI)  begin r[F_WBD0] = 1; r[F_WBSUB] = 0; r[F_WBD2] = 0; r[F_WBD5] = 1; end
        if (isLd) begin r[F_WBD0] = 1; r[F_WBD1] = 1; r[F_WBD2] = 1; r[F_WBD5] = 1; end
        if (isSd) begin r[F_RAMD0] = 1; r[F_RAMD1] = 0; end
        if (isBr) r[F_NSUB] = 1;
        if (isAu) begin r[F_WBD5] = 0; r[F_WBD4] = 1; r[F_ND4] = 0; end
        if (isJal || isJalr) begin r[F_WBD5] = 0; r[F_WBD4] = 0; end
        return r;
    endfunction

    function automatic logic [31:0] genInstr(input int kind);
        logic [31:0] ir;
        ir = $urandom();
        case (kind)
            0: begin ir[6:0] = 7'h33; ir[14:12] = 3'd0; end
            1: begin ir[6:0] = 7'h13; ir[14:12] = 3'd0; end
            2: begin ir[6:0] = 7'h03; ir[14:12] = 3'd3; end
            3: begin ir[6:0] = 7'h23; ir[14:12] = 3'd3; end
            4: begin
                ir[6:0] = 7'h63;
                case ($urandom_range(0, 5))
                    0: ir[14:12] = 3'd0;
                    1: ir[14:12] = 3'd1;
                    2: ir[14:12] = 3'd4;
                    3: ir[14:12] = 3'd5;
                    4: ir[14:12] = 3'd6;
                    default: ir[14:12] = 3'd7;
                endcase
            end
            5: ir[6:0] = 7'h17;
            6: ir[6:0] = 7'h6F;
            7: begin
                ir[6:0] = 7'h67;
                if (ir[11:7] == ir[19:15]) ir[11:7] = ir[19:15] + 5'd1;
            end
            8: ;
            9: begin
                ir[6:0]   = 7'h67;
                ir[11:7]  = 5'($urandom_range(1, 31));
                ir[19:15] = ir[11:7];
            end
            default: begin
                case ($urandom_range(0, 3))
                    0: begin ir[6:0] = 7'h33; ir[14:12] = 3'($urandom_range(1, 7)); end
                    1: begin ir[6:0] = 7'h03; ir[14:12] = 3'($urandom_range(0, 2)); end
                    2: begin ir[6:0] = 7'h23; ir[14:12] = 3'($urandom_range(4, 7)); end
                    default: begin ir[6:0] = 7'h63; ir[14:12] = 3'($urandom_range(2, 3)); end
                endcase
            end
        endcase
        return ir;
    endfunction

    task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic checkOutput(input rec_t act);
        rec_t exp;
        if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected instruction end: scoreboard empty");
            return;
        end
        exp = sbQ.pop_front();
        for (int i = 0; i < NF; i++) begin
            if (exp[i] != DC) begin
                checks++;
                if (act[i] !== exp[i]) begin
                    errors++;
                    $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)",
                             fieldName[i], act[i], exp[i], $time);
                end
            end
        end
    endtask

    // Monitor: rebuild one record per instruction from FETCH to PC update or halt.
    rec_t act;
    int   cyc = 0;
    bit   active = 0;
    bit   pending = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                active  = 0;
                pending = 0;
            end else begin
                if (pending) begin
                    act[F_CNT] = instr_count;
                    checkOutput(act);
                    pending = 0;
                end
                if (state == 3'd2 && !halted) begin
                    for (int i = 0; i < NF; i++) act[i] = 32'd0;
                    act[F_WECYC]  = NONE;
                    act[F_RAMCYC] = NONE;
                    cyc    = 0;
                    active = 1;
                end else if (active) begin
                    cyc++;
                end
                if (active) begin
                    if (load_IR) act[F_IRCNT] = act[F_IRCNT] + 1;
                    if (load_PC) act[F_PCCNT] = act[F_PCCNT] + 1;
                    if (we) begin
                        act[F_WECNT] = act[F_WECNT] + 1;
                        act[F_WECYC] = cyc;
                        act[F_WBD0]  = b2w(decisor0);
                        act[F_WBD1]  = b2w(decisor1);
                        act[F_WBD2]  = b2w(decisor2);
                        act[F_WBD4]  = b2w(decisor4);
                        act[F_WBD5]  = b2w(decisor5);
                        act[F_WBSUB] = b2w(somador_subtrator);
                    end
                    if (we_ram) begin
                        act[F_RAMCNT] = act[F_RAMCNT] + 1;
                        act[F_RAMCYC] = cyc;
                        act[F_RAMD0]  = b2w(decisor0);
                        act[F_RAMD1]  = b2w(decisor1);
                    end
                    if (load_PC && decisor3) begin
                        act[F_HALT] = b2w(halted);
                        act[F_ILL]  = b2w(illegal);
                        act[F_LAST] = cyc;
                        act[F_ND4]  = b2w(decisor4);
                        act[F_ND6]  = b2w(decisor6);
                        act[F_NSUB] = b2w(somador_subtrator);
                        pending = 1;
                        active  = 0;
                    end else if (halted) begin
                        act[F_HALT] = 1;
                        act[F_ILL]  = b2w(illegal);
                        act[F_LAST] = cyc;
                        act[F_CNT]  = instr_count;
                        checkOutput(act);
                        active = 0;
                    end else if (cyc > 20) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL instruction never completed: state %0d", state);
                        active = 0;
                    end
                end
            end
        end
    end

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkValue("reset strobes", {28'd0, we, we_ram, load_PC, load_IR}, 32'd0);
        checkValue("reset selects", {24'd0, decisor6, decisor5, decisor4, decisor3,
                                     decisor2, decisor1, decisor0, somador_subtrator}, 32'h40);
        checkValue("reset halted/illegal", {30'd0, halted, illegal}, 32'd0);
        checkValue("reset instr_count", instr_count, 32'd0);
        checkValue("reset state", {29'd0, state}, 32'd0);
        reset = 1'b0;
        sbQ.delete();
        modelCount = 0;
    endtask

    // Wait for the next FETCH; scramble flags and IR while in NEXT to prove they are ignored there.
    task automatic waitFetch(output bit ok);
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (state == 3'd2 && !halted) ok = 1;
            else if (state == 3'd7) begin
                {BGEU, BLTU, BGE, BLT, BNE, BEQ} = 6'($urandom());
                saida_IR = $urandom();
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL fetch timeout: state %0d", state);
        end
    endtask

    task automatic handleHalt();
        bit seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (halted) seen = 1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL halt timeout: halted %0d state %0d", halted, state);
        end else begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                checkValue("halt strobes", {28'd0, we, we_ram, load_PC, load_IR}, 32'd0);
                checkValue("halt held", {30'd0, halted, illegal}, 32'd3);
                checkValue("halt instr_count", instr_count, modelCount);
            end
        end
        doReset();
    endtask

    task automatic applyStimulus(input logic [31:0] ir, input logic [5:0] flg);
        bit   ok;
        rec_t exp;
        waitFetch(ok);
        if (!ok) return;
        saida_IR = ir;
        {BGEU, BLTU, BGE, BLT, BNE, BEQ} = flg;
        exp = model(ir, flg, modelCount);
        sbQ.push_back(exp);
        if (exp[F_HALT] == 1) handleHalt();
        else modelCount++;
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL global timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int  k;
        bit  seenWe;
        reset    = 1'b1;
        saida_IR = 32'd0;
        {BGEU, BLTU, BGE, BLT, BNE, BEQ} = 6'd0;
        doReset();

        applyStimulus(32'h00910093, 6'd0);
        applyStimulus(32'h00103203, 6'd0);
        applyStimulus(32'h00411463, 6'b000010);
        applyStimulus(32'h00411463, 6'b111101);
        applyStimulus(32'h008000EF, 6'd0);
        applyStimulus(32'h00000000, 6'd0);
        applyStimulus(32'h00010167, 6'd0);

        for (int n = 0; n < 150; n++) begin
            k = $urandom_range(0, 12);
            if (k > 10) k = 4;
            applyStimulus(genInstr(k), 6'($urandom()));
        end

        // Abort a load in write-back; nothing may be written or counted afterwards.
        applyStimulus(32'h00110093, 6'd0);
        applyStimulus(32'h00103203, 6'd0);
        seenWe = 0;
        for (int i = 0; i < 10 && !seenWe; i++) begin
            @(negedge clk);
            if (we) seenWe = 1;
        end
        checkValue("ld reached WB", {31'd0, seenWe}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        checkValue("abort strobes", {29'd0, we, we_ram, load_PC}, 32'd0);
        checkValue("abort state", {29'd0, state}, 32'd0);
        checkValue("abort instr_count", instr_count, 32'd0);
        checkValue("abort decisor5", {31'd0, decisor5}, 32'd1);
        reset = 1'b0;
        sbQ.delete();
        modelCount = 0;

        applyStimulus(32'h00910093, 6'd0);
        for (int i = 0; i < 20 && sbQ.size() != 0; i++) @(negedge clk);
        checkValue("scoreboard drained", sbQ.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
